seq_frame_tx: RTL and testbench
===============================

Name: seq_frame_tx

Overview:
- Serial frame transmitter. Accepts a parallel payload word over a valid/ready handshake and emits one bit per clock on dout.
- Each frame is the 4-bit sync word 1011, MSB first, followed by the payload, MSB first.
- Sits on the transmit side of the serial link, opposite the receive-side 1011 Mealy detector; used as the stimulus source for it in loopback.
- Idle line is held at 0, so no sync word is emitted between frames.

Parameters:
- DATA_W, 8, payload width in bits (legal range 1..32).
- SYNC_W, 4, sync word width in bits.
- SYNC, 4'b1011, sync word pattern, transmitted MSB first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- din_valid  input  1  payload word offered.
- din  input  DATA_W  payload word; sampled only on accept.
- din_ready  output  1  block can take a word this cycle (combinational from registered state/counter).
- dout  output  1  serial line bit (registered).
- dout_valid  output  1  dout carries a sync or payload bit (registered).
- busy  output  1  frame in progress (registered).
- frame_done  output  1  one-cycle pulse, coincident with the last payload bit on dout (registered).

Behaviour:
- Reset (synchronous, on a clk edge with reset=1): state=IDLE, dout=0, dout_valid=0, busy=0, frame_done=0, bit counter=0, shift register=0.
- Reset has priority over everything. Reset asserted mid-frame aborts the frame; dout=0 from the next edge on. The partial frame is not resumed.
- Accept: a word is taken on an edge where din_valid && din_ready. din is captured into the payload shift register on that edge.
- din_ready=1 in IDLE, and in DATA during the last payload bit (counter==DATA_W-1). It is 0 at all other times. din is ignored when not accepted.
- FSM states:
  - IDLE: dout=0, dout_valid=0, busy=0. On accept -> SYNC, counter=0.
  - SYNC: dout=SYNC[SYNC_W-1-counter], dout_valid=1, busy=1. Counter increments each cycle; on counter==SYNC_W-1 -> DATA, counter=0.
  - DATA: dout=payload MSB, shift left each cycle, dout_valid=1, busy=1. On counter==DATA_W-1, frame_done=1 in that same output cycle. Then:
    - if an accept occurs on that edge -> SYNC with the new word (back-to-back);
    - else -> IDLE.
- Latency: first sync bit appears on dout the cycle after the accept edge. The last payload bit appears SYNC_W+DATA_W cycles after accept.
- Back-to-back frames: period is exactly SYNC_W+DATA_W cycles, with no idle gap. dout_valid stays 1 across the frame boundary.
- Payload content is not scrubbed. A payload containing 1011 is transmitted as-is; false detection downstream is a system-level concern.
- din_valid may drop without having been accepted; no protocol violation.
- din changing while not accepted has no effect.
- Counter width is clog2(max(SYNC_W,DATA_W)). It never wraps past its terminal value; the terminal compare reloads it to 0.

Decomposition:
- Shared package seq_pkg holds:
  - SYNC_W and SYNC constants (shared with the receive-side detector);
  - state encoding localparams IDLE=2'b00, SYNC=2'b01, DATA=2'b10;
  - a state typedef.
- One natural sub-module: seq_piso, a DATA_W parallel-in/serial-out shift register with load and shift enables. The FSM and counter stay in seq_frame_tx.

Test Plan:
- Reset, then idle 10 cycles with din_valid=0 -> dout=0, dout_valid=0, busy=0, din_ready=1 throughout.
- Single frame, din=8'hA5 accepted at edge T:
  - cycles T+1..T+12: dout = 1,0,1,1, 1,0,1,0,0,1,0,1;
  - frame_done=1 only at T+12; din_ready=1 at T+12;
  - at T+13: IDLE, dout=0.
- Back-to-back: 8'hFF then 8'h00, with din_valid held high -> second accept on the last-bit edge of frame 1. Stream is 1011 11111111 1011 00000000 with dout_valid continuously 1 for 24 cycles, and two frame_done pulses 12 cycles apart.
- Reset at cycle T+6 of a frame with din=8'h3C -> from the next edge dout=0, dout_valid=0, busy=0, din_ready=1. A new accept then starts a clean frame with the sync word.
- Handshake hold-off: din_valid=1 with din changing every cycle while busy -> only the value present on the accept edge is transmitted; din_ready=0 in all cycles except the last payload bit.
- Loopback into the 1011 detector:
  - din=8'h00 -> exactly one detection, on the 4th sync bit;
  - din=8'h0B -> two detections (sync and payload tail), confirming that payload is not scrubbed.

Source files
------------

// File: rtl/seq_pkg.sv
// Constants and types shared by the serial frame transmitter and the
// receive-side 1011 detector.
package seq_pkg;

    // Sync word that opens every frame, transmitted MSB first.
    localparam int              SYNC_W = 4;
    localparam logic [SYNC_W-1:0] SYNC = 4'b1011;

    // Transmitter FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SYNC = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    // Sync bit sent at position idx (0 = first bit on the line).
    function automatic logic sync_bit(input int unsigned idx);
        logic [SYNC_W-1:0] shifted;
        shifted = SYNC << idx;
        return shifted[SYNC_W-1];
    endfunction

    // Bit counter width: wide enough to index the longer of sync and payload.
    function automatic int unsigned cnt_width(input int unsigned data_w);
        int unsigned longest;
        longest = (data_w > SYNC_W) ? data_w : SYNC_W;
        return $clog2(longest);
    endfunction

endpackage

// File: rtl/seq_piso.sv
// Parallel-in / serial-out shift register. Load wins over shift; the MSB of
// the value about to be registered is exported so the caller can register
// the outgoing line bit in the same cycle the register updates.
module seq_piso #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              msb_next
);

    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] data_n;

    // Select the next register content: new word, shifted word, or hold.
    always_comb begin
        data_n = data;
        if (load) begin
            data_n = din;
        end else if (shift) begin
            data_n = data << 1;
        end
        msb_next = data_n[DATA_W-1];
    end

    // Payload storage, cleared on reset so no stale word survives an abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
        end else begin
            data <= data_n;
        end
    end

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: each accepted payload word goes out as the sync
// word followed by the payload, MSB first, one bit per clock. The line idles
// at 0. The state/counter pair describes the bit currently on dout.
module seq_frame_tx
    import seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic              din_ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned      CNT_W     = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             accept;
    logic             load;
    logic             shift;
    logic             msb_next;
    logic             dout_n;
    logic             dout_valid_n;
    logic             frame_done_n;

    // Ready while idle, or while the last payload bit is on the line so the
    // next frame can follow with no gap.
    assign din_ready = (state == ST_IDLE) || (state == ST_DATA && cnt == DATA_LAST);
    assign accept    = din_valid && din_ready;

    seq_piso #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift    (shift),
        .din      (din),
        .msb_next (msb_next)
    );

    // Next state, counter and shift-register controls.
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_SYNC;
                    cnt_n   = '0;
                    load    = 1'b1;
                end
            end
            ST_SYNC: begin
                if (cnt == SYNC_LAST) begin
                    state_n = ST_DATA;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt == DATA_LAST) begin
                    cnt_n = '0;
                    if (accept) begin
                        state_n = ST_SYNC;
                        load    = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                    shift = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Line values for the bit that the next state/counter will describe.
    always_comb begin
        dout_n = 1'b0;
        unique case (state_n)
            ST_SYNC: dout_n = sync_bit(32'(cnt_n));
            ST_DATA: dout_n = msb_next;
            default: dout_n = 1'b0;
        endcase
        dout_valid_n = (state_n != ST_IDLE);
        frame_done_n = (state_n == ST_DATA) && (cnt_n == DATA_LAST);
    end

    // State, counter and registered line outputs; reset aborts any frame.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            dout       <= dout_n;
            dout_valid <= dout_valid_n;
            busy       <= dout_valid_n;
            frame_done <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Self-checking bench for seq_frame_tx. A queue of expected line bits is
// filled with {1011, payload} whenever the bench expects a word to be taken;
// each clock pops one entry (empty queue = idle line).
module tb_seq_frame_tx;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              din_valid;
    logic [DATA_W-1:0] din;
    logic              din_ready;
    logic              dout;
    logic              dout_valid;
    logic              busy;
    logic              frame_done;

    typedef struct packed {
        logic b;
        logic done;
    } exp_t;

    exp_t        exp_q[$];
    logic        exp_ready;
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic [3:0]  hist;
    int          det_count;
    int          det_first;

    always #5 clk = ~clk;

    seq_frame_tx #(
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din_valid  (din_valid),
        .din        (din),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // One clock: check ready, drive inputs, update the model, step to the
    // next falling edge and compare the line against the model.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic r);
        exp_t                     e;
        logic                     active;
        logic [DATA_W+3:0]        frame;
        check("din_ready", {31'd0, din_ready}, {31'd0, exp_ready});
        reset     = r;
        din_valid = v;
        din       = d;
        if (r) begin
            exp_q.delete();
        end else if (v && exp_ready) begin
            frame = {4'b1011, d};
            for (int i = DATA_W + 3; i >= 0; i--) begin
                exp_q.push_back('{b: frame[i], done: (i == 0)});
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (exp_q.size() != 0) begin
            e      = exp_q.pop_front();
            active = 1'b1;
        end else begin
            e      = '0;
            active = 1'b0;
        end
        check("dout",       {31'd0, dout},       {31'd0, e.b});
        check("dout_valid", {31'd0, dout_valid}, {31'd0, active});
        check("busy",       {31'd0, busy},       {31'd0, active});
        check("frame_done", {31'd0, frame_done}, {31'd0, e.done});
        exp_ready = (exp_q.size() == 0);
        hist = {hist[2:0], dout};
        if (hist == 4'b1011) begin
            det_count++;
            if (det_count == 1) det_first = cyc;
        end
    endtask

    initial begin
        logic [11:0]       stream;
        int                valid_cnt;
        int                done_cnt;
        int                c0;
        logic [DATA_W-1:0] rd;

        reset     = 1'b1;
        din_valid = 1'b0;
        din       = '0;
        hist      = '0;
        det_count = 0;
        det_first = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_ready = 1'b1;

        // Reset state, then a quiet idle line.
        cycle(1'b0, '0, 1'b1);
        repeat (10) cycle(1'b0, 8'h5A, 1'b0);

        // Single frame with 0xA5.
        stream = '0;
        cycle(1'b1, 8'hA5, 1'b0);
        stream = {stream[10:0], dout};
        repeat (11) begin
            cycle(1'b0, 8'h00, 1'b0);
            stream = {stream[10:0], dout};
        end
        check("a5_stream", {20'd0, stream}, 32'h0000_0BA5);
        repeat (2) cycle(1'b0, 8'h00, 1'b0);

        // Back-to-back 0xFF then 0x00 with valid held high.
        valid_cnt = 0;
        done_cnt  = 0;
        cycle(1'b1, 8'hFF, 1'b0);
        valid_cnt += int'(dout_valid);
        repeat (12) begin
            cycle(1'b1, 8'h00, 1'b0);
            valid_cnt += int'(dout_valid);
            done_cnt  += int'(frame_done);
        end
        repeat (13) begin
            cycle(1'b0, 8'h00, 1'b0);
            valid_cnt += int'(dout_valid);
            done_cnt  += int'(frame_done);
        end
        check("b2b_valid_cycles", valid_cnt, 24);
        check("b2b_done_pulses",  done_cnt,  2);

        // Abort a 0x3C frame at T+6, then a clean new frame.
        cycle(1'b1, 8'h3C, 1'b0);
        repeat (5) cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h96, 1'b0);
        repeat (13) cycle(1'b0, 8'h00, 1'b0);

        // Hold-off: valid high, payload changing every cycle.
        repeat (40) begin
            rd = DATA_W'($urandom);
            cycle(1'b1, rd, 1'b0);
        end
        repeat (13) cycle(1'b0, 8'h00, 1'b0);

        // Loopback into a 1011 detector: sync only.
        hist      = '0;
        det_count = 0;
        det_first = 0;
        c0        = cyc;
        cycle(1'b1, 8'h00, 1'b0);
        repeat (14) cycle(1'b0, 8'h00, 1'b0);
        check("loop_00_count", det_count, 1);
        check("loop_00_pos",   det_first - c0, 4);

        // Payload carrying 1011 is not scrubbed.
        hist      = '0;
        det_count = 0;
        cycle(1'b1, 8'h0B, 1'b0);
        repeat (14) cycle(1'b0, 8'h00, 1'b0);
        check("loop_0b_count", det_count, 2);

        // Random traffic with occasional resets.
        repeat (400) begin
            rd = DATA_W'($urandom);
            cycle(($urandom % 3) != 0, rd, ($urandom % 50) == 0);
        end
        repeat (13) cycle(1'b0, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
